seven_scan: RTL and testbench

SEVEN_SCAN -- requirements
Module: seven_scan

---
 rtl/seven_pkg.sv | 7 +
 rtl/seven_scan_if.sv | 21 ++
 rtl/displaydigit.sv | 31 +++
 rtl/seven_scan.sv | 103 ++++++++++
 tb/tb_seven_scan.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/seven_pkg.sv
// Shared constants for the seven-segment scan display.
package seven_pkg;
  localparam int SEG_W = 8;
  typedef logic [SEG_W-1:0] seg_t;
  localparam seg_t SEG_BLANK = 8'h00;
  localparam seg_t SEG_DASH  = 8'h40;
endpackage

// File: rtl/seven_scan_if.sv
// Data/control bundle between the display host and the scan controller.
interface seven_scan_if #(parameter int DIGITS = 4);
  logic [4*DIGITS-1:0] in;
  logic                load;
  logic                signal;
  logic                lz_suppress;
  logic [DIGITS-1:0]   blink_mask;
  logic [7:0]          seg_out;
  logic [DIGITS-1:0]   dig_sel;
  logic                frame_tick;

  modport master (
    output in, load, signal, lz_suppress, blink_mask,
    input  seg_out, dig_sel, frame_tick
  );

  modport slave (
    input  in, load, signal, lz_suppress, blink_mask,
    output seg_out, dig_sel, frame_tick
  );
endinterface

// File: rtl/displaydigit.sv
// Hex nibble to seven-segment decoder, bit 0 = segment a .. bit 6 = g, bit 7 = dp.
module displaydigit
  import seven_pkg::*;
(
  input  logic [3:0] bin,
  output seg_t       led
);

  // combinational hex decode
  always_comb begin
    case (bin)
      4'h0: led = 8'h3F;
      4'h1: led = 8'h06;
      4'h2: led = 8'h5B;
      4'h3: led = 8'h4F;
      4'h4: led = 8'h66;
      4'h5: led = 8'h6D;
      4'h6: led = 8'h7D;
      4'h7: led = 8'h07;
      4'h8: led = 8'h7F;
      4'h9: led = 8'h6F;
      4'hA: led = 8'h77;
      4'hB: led = 8'h7C;
      4'hC: led = 8'h39;
      4'hD: led = 8'h5E;
      4'hE: led = 8'h79;
      4'hF: led = 8'h71;
      default: led = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/seven_scan.sv
// Multiplexed seven-segment scanner: free-running prescaler/index/blink
// counters, registered segment and digit-select outputs.
module seven_scan
  import seven_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int PRESCALE  = 50000,
  parameter int BLINK_DIV = 64
) (
  input  logic clk,
  input  logic rst_n,
  seven_scan_if.slave bus
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = $clog2(PRESCALE);
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic [PW-1:0]       pre_q, pre_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [FW-1:0]       frm_q, frm_d;
  logic                blink_q, blink_d;
  seg_t                seg_q, seg_d;
  logic [DIGITS-1:0]   dig_q, dig_d;
  logic                tick_q;

  logic                slot_wrap, frame_wrap;
  logic [3:0]          nib;
  seg_t                dec_led;
  logic [DIGITS-1:0]   lz_blank;
  logic                allz;
  logic                blank;

  displaydigit u_dec (.bin(nib), .led(dec_led));

  // counter chain and display register next-state
  always_comb begin
    slot_wrap  = (pre_q == PW'(PRESCALE - 1));
    frame_wrap = slot_wrap && (idx_q == IW'(DIGITS - 1));
    pre_d      = slot_wrap ? '0 : pre_q + 1'b1;
    idx_d      = idx_q;
    frm_d      = frm_q;
    blink_d    = blink_q;
    if (slot_wrap) idx_d = frame_wrap ? '0 : idx_q + 1'b1;
    if (frame_wrap) begin
      if (frm_q == FW'(BLINK_DIV - 1)) begin
        frm_d   = '0;
        blink_d = ~blink_q;
      end else begin
        frm_d = frm_q + 1'b1;
      end
    end
    disp_d = bus.load ? bus.in : disp_q;
  end

  // leading-zero map: digit k is blank-eligible when nibbles k..top are all zero
  always_comb begin
    lz_blank = '0;
    allz     = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      allz        = allz && (disp_q[4*k +: 4] == 4'h0);
      lz_blank[k] = allz;
    end
  end

  // output pattern for the digit currently being scanned
  always_comb begin
    nib   = disp_q[{idx_q, 2'b00} +: 4];
    blank = (bus.lz_suppress && lz_blank[idx_q]) ||
            (blink_q && bus.blink_mask[idx_q]);
    seg_d = bus.signal ? (blank ? SEG_BLANK : dec_led) : SEG_BLANK;
    dig_d = bus.signal ? (DIGITS'(1) << idx_q) : '0;
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q  <= '0;
      pre_q   <= '0;
      idx_q   <= '0;
      frm_q   <= '0;
      blink_q <= 1'b0;
      seg_q   <= SEG_BLANK;
      dig_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      disp_q  <= disp_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      frm_q   <= frm_d;
      blink_q <= blink_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
      tick_q  <= frame_wrap;
    end
  end

  assign bus.seg_out    = seg_q;
  assign bus.dig_sel    = dig_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seven_scan.sv
// Directed bench for seven_scan with a cycle-count reference model.
module tb_seven_scan;
  localparam int D = 4;
  localparam int P = 4;
  localparam int B = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seven_scan_if #(.DIGITS(D)) bus();
  seven_scan #(.DIGITS(D), .PRESCALE(P), .BLINK_DIV(B)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  int edge_n = 0;

  logic [7:0] hex_seg [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: c counts clock edges since reset release
  int         c = 0;
  logic [15:0] mdisp = '0;
  logic [7:0] e_seg;
  logic [3:0] e_dig;
  logic       e_ft;

  always @(posedge clk) begin : model
    int idx;
    int frame;
    logic ph;
    logic blank;
    logic [3:0] nib;
    if (!rst_n) begin
      e_seg = 8'h00; e_dig = 4'h0; e_ft = 1'b0;
      c = 0; mdisp = '0;
    end else begin
      idx   = (c / P) % D;
      frame = c / (P * D);
      ph    = ((frame / B) % 2) == 1;
      nib   = mdisp[idx*4 +: 4];
      blank = (bus.lz_suppress && idx > 0 && (mdisp >> (idx*4)) == 16'h0) ||
              (ph && bus.blink_mask[idx]);
      e_seg = bus.signal ? (blank ? 8'h00 : hex_seg[nib]) : 8'h00;
      e_dig = bus.signal ? 4'(1 << idx) : 4'h0;
      e_ft  = (c % (P * D)) == (P * D - 1);
      c++;
      if (bus.load) mdisp = bus.in;
    end
    #1;
    chk("model_seg", {24'h0, bus.seg_out}, {24'h0, e_seg});
    chk("model_dig", {28'h0, bus.dig_sel}, {28'h0, e_dig});
    chk("model_ft", {31'h0, bus.frame_tick}, {31'h0, e_ft});
  end

  task automatic goto_edge(input int k);
    while (edge_n < k) begin
      @(posedge clk);
      edge_n++;
    end
    #2;
  endtask

  task automatic lit(input string name, input logic [7:0] seg, input logic [3:0] dig);
    chk({name, "_seg"}, {24'h0, bus.seg_out}, {24'h0, seg});
    chk({name, "_dig"}, {28'h0, bus.dig_sel}, {28'h0, dig});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in = '0; bus.load = 0; bus.signal = 0; bus.lz_suppress = 0; bus.blink_mask = '0;
    repeat (3) @(negedge clk);
    lit("reset", 8'h00, 4'h0);
    chk("reset_ft", {31'h0, bus.frame_tick}, 32'h0);

    // basic scan, blink on digit 2
    bus.in = 16'h1234; bus.load = 1; bus.signal = 1; bus.blink_mask = 4'b0100;
    @(negedge clk); rst_n = 1; edge_n = 0;
    goto_edge(1);  lit("disp_zero_after_reset", 8'h3F, 4'h1);
    @(negedge clk); bus.load = 0;
    goto_edge(2);  lit("scan_d0", 8'h66, 4'h1);
    goto_edge(6);  lit("scan_d1", 8'h4F, 4'h2);
    goto_edge(10); lit("scan_d2", 8'h5B, 4'h4);
    goto_edge(14); lit("scan_d3", 8'h06, 4'h8);
    goto_edge(16); chk("ft_first", {31'h0, bus.frame_tick}, 32'h1);
    goto_edge(17); chk("ft_pulse_end", {31'h0, bus.frame_tick}, 32'h0);
    lit("scan_wrap_d0", 8'h66, 4'h1);
    goto_edge(26); lit("blink_f1_lit", 8'h5B, 4'h4);
    goto_edge(32); chk("ft_second", {31'h0, bus.frame_tick}, 32'h1);
    goto_edge(38); lit("blink_f2_d1", 8'h4F, 4'h2);
    goto_edge(42); lit("blink_f2_dark", 8'h00, 4'h4);
    goto_edge(74); lit("blink_f4_lit", 8'h5B, 4'h4);

    // display disabled for 10 cycles
    @(negedge clk); bus.signal = 0;
    goto_edge(80); lit("sig_off", 8'h00, 4'h0);
    chk("sig_off_ft", {31'h0, bus.frame_tick}, 32'h1);
    goto_edge(84);
    @(negedge clk); bus.signal = 1;
    goto_edge(85); lit("sig_resume", 8'h4F, 4'h2);

    // async reset while digit 2 is active
    goto_edge(90); lit("pre_rst_d2", 8'h5B, 4'h4);
    #2; rst_n = 0;
    #1; lit("async_rst", 8'h00, 4'h0);
    chk("async_rst_ft", {31'h0, bus.frame_tick}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1; edge_n = 0;
    goto_edge(1); lit("post_rst_e1", 8'h3F, 4'h1);
    goto_edge(4); lit("post_rst_e4", 8'h3F, 4'h1);
    goto_edge(5); lit("post_rst_e5", 8'h3F, 4'h2);

    // leading-zero suppression on 0050
    @(negedge clk); rst_n = 0;
    bus.in = 16'h0050; bus.load = 1; bus.lz_suppress = 1; bus.blink_mask = '0;
    @(negedge clk); @(negedge clk); rst_n = 1; edge_n = 0;
    goto_edge(1);
    @(negedge clk); bus.load = 0;
    goto_edge(2);  lit("lz_d0", 8'h3F, 4'h1);
    goto_edge(6);  lit("lz_d1", 8'h6D, 4'h2);
    goto_edge(10); lit("lz_d2", 8'h00, 4'h4);
    goto_edge(14); lit("lz_d3", 8'h00, 4'h8);
    @(negedge clk); bus.lz_suppress = 0;
    goto_edge(15); lit("nolz_d3_immediate", 8'h3F, 4'h8);
    goto_edge(26); lit("nolz_d2", 8'h3F, 4'h4);

    // all-zero value with suppression
    @(negedge clk); bus.lz_suppress = 1; bus.in = 16'h0000; bus.load = 1;
    goto_edge(27);
    @(negedge clk); bus.load = 0;
    goto_edge(34); lit("zero_d0", 8'h3F, 4'h1);
    goto_edge(38); lit("zero_d1", 8'h00, 4'h2);
    goto_edge(42); lit("zero_d2", 8'h00, 4'h4);
    goto_edge(46); lit("zero_d3", 8'h00, 4'h8);

    // load on the same edge as a slot advance
    goto_edge(55);
    @(negedge clk); bus.in = 16'h0700; bus.load = 1;
    goto_edge(56); lit("adv_load_old", 8'h00, 4'h2);
    @(negedge clk); bus.load = 0;
    goto_edge(57); lit("adv_load_new", 8'h07, 4'h4);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
